es9821q_init_sequencer: RTL and testbench

- Brings up the ES9821Q ADC after system reset: pulses the ADC hardware reset, waits a settle time, then writes a register table over I2C.
- Sits between the ES9821Q top level and the byte-level I2C write master, driving that master through a valid/ready command port and collecting its per-transaction ACK status.
- Retries NACKed or timed-out writes, then reports done or error together with the failing table index.

---
 rtl/es9821q_init_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_es9821q_init_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/es9821q_init_sequencer.sv
// ES9821Q bring-up sequencer: pulses the ADC hardware reset, waits for settling,
// then writes a register table through a byte-level I2C write master with retries.

package es9821q_init_sequencer_pkg;
  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } i2c_wr_t;
endpackage

module es9821q_init_sequencer
  import es9821q_init_sequencer_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR       = 7'h40,
  parameter int unsigned NUM_REGS       = 16,
  parameter int unsigned RST_CYCLES     = 1000,
  parameter int unsigned SETTLE_CYCLES  = 100000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned BACKOFF_CYCLES = 5000,
  parameter int unsigned RSP_TIMEOUT    = 200000,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  tbl_idx,
  input  logic [15:0] tbl_entry,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [6:0]  cmd_dev_addr,
  output logic [7:0]  cmd_reg,
  output logic [7:0]  cmd_data,
  input  logic        rsp_valid,
  input  logic        rsp_ack_err,
  output logic        adc_rst_n,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_idx,
  output logic [7:0]  retry_total
);

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned RETRY_W = 4;

  // Terminal count values; a zero-length delay still occupies one cycle.
  localparam logic [CNT_W-1:0] RST_LAST    = (RST_CYCLES     == 0) ? '0 : CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = (SETTLE_CYCLES  == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BO_LAST     = (BACKOFF_CYCLES == 0) ? '0 : CNT_W'(BACKOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = (RSP_TIMEOUT    == 0) ? '0 : CNT_W'(RSP_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REGS - 1);
  localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_ADC,
    S_SETTLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_RSP,
    S_BACKOFF,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  i2c_wr_t            cmd_q, cmd_d;
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic               auto_pend_q, auto_pend_d;
  logic               launch;

  logic [IDX_W-1:0]   tbl_idx_d;
  logic               cmd_valid_d;
  logic               adc_rst_n_d;
  logic               busy_d;
  logic               done_d;
  logic               error_d;
  logic [IDX_W-1:0]   err_idx_d;
  logic [7:0]         retry_total_d;

  assign cmd_dev_addr = DEV_ADDR;
  assign cmd_reg      = cmd_q.reg_addr;
  assign cmd_data     = cmd_q.data;

  // Next-state and next-output computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_d         = cmd_q;
    retry_cnt_d   = retry_cnt_q;
    auto_pend_d   = auto_pend_q;
    tbl_idx_d     = tbl_idx;
    cmd_valid_d   = cmd_valid;
    adc_rst_n_d   = adc_rst_n;
    busy_d        = busy;
    done_d        = done;
    error_d       = error;
    err_idx_d     = err_idx;
    retry_total_d = retry_total;
    launch        = 1'b0;

    case (state_q)
      S_IDLE: launch = auto_pend_q | start;

      S_RST_ADC: begin
        if (cnt_q == RST_LAST) begin
          state_d     = S_SETTLE;
          cnt_d       = '0;
          adc_rst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_LOAD: begin
        cmd_d       = tbl_entry;
        retry_cnt_d = '0;
        cmd_valid_d = 1'b1;
        state_d     = S_ISSUE;
      end

      S_ISSUE: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_WAIT_RSP;
        end
      end

      // A response landing on the expiry cycle wins over the timeout.
      S_WAIT_RSP: begin
        if (rsp_valid && !rsp_ack_err) begin
          if (tbl_idx == LAST_IDX) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            tbl_idx_d = tbl_idx + IDX_W'(1);
            state_d   = S_LOAD;
          end
        end else if (rsp_valid || (cnt_q == TO_LAST)) begin
          if (retry_cnt_q < MAX_RETRY_C) begin
            retry_cnt_d = retry_cnt_q + RETRY_W'(1);
            if (retry_total != 8'hFF) begin
              retry_total_d = retry_total + 8'd1;
            end
            cnt_d   = '0;
            state_d = S_BACKOFF;
          end else begin
            state_d   = S_ERROR;
            busy_d    = 1'b0;
            error_d   = 1'b1;
            err_idx_d = tbl_idx;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_BACKOFF: begin
        if (cnt_q == BO_LAST) begin
          cmd_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE, S_ERROR: launch = start;

      default: state_d = S_IDLE;
    endcase

    // Every run starts from a clean slate with the ADC held in reset.
    if (launch) begin
      state_d       = S_RST_ADC;
      cnt_d         = '0;
      auto_pend_d   = 1'b0;
      tbl_idx_d     = '0;
      cmd_valid_d   = 1'b0;
      adc_rst_n_d   = 1'b0;
      busy_d        = 1'b1;
      done_d        = 1'b0;
      error_d       = 1'b0;
      err_idx_d     = '0;
      retry_total_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      retry_cnt_q <= '0;
      auto_pend_q <= AUTO_START;
      tbl_idx     <= '0;
      cmd_valid   <= 1'b0;
      adc_rst_n   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_idx     <= '0;
      retry_total <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      retry_cnt_q <= retry_cnt_d;
      auto_pend_q <= auto_pend_d;
      tbl_idx     <= tbl_idx_d;
      cmd_valid   <= cmd_valid_d;
      adc_rst_n   <= adc_rst_n_d;
      busy        <= busy_d;
      done        <= done_d;
      error       <= error_d;
      err_idx     <= err_idx_d;
      retry_total <= retry_total_d;
    end
  end

endmodule

// File: tb/tb_es9821q_init_sequencer.sv
// Bench for es9821q_init_sequencer: scenario table plus an I2C master model
// that scoreboards every accepted command against a bench-built expectation queue.

module tb_es9821q_init_sequencer;

  localparam int NREG = 3;
  localparam int MAXR = 2;
  localparam int BO   = 4;
  localparam int TO   = 16;
  localparam int RSTC = 4;
  localparam int SETC = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  tbl_idx;
  logic [15:0] tbl_entry;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [6:0]  cmd_dev_addr;
  logic [7:0]  cmd_reg;
  logic [7:0]  cmd_data;
  logic        rsp_valid = 1'b0;
  logic        rsp_ack_err = 1'b0;
  logic        adc_rst_n;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  err_idx;
  logic [7:0]  retry_total;

  es9821q_init_sequencer #(
    .DEV_ADDR(7'h40), .NUM_REGS(NREG), .RST_CYCLES(RSTC), .SETTLE_CYCLES(SETC),
    .MAX_RETRY(MAXR), .BACKOFF_CYCLES(BO), .RSP_TIMEOUT(TO), .AUTO_START(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tbl_idx(tbl_idx), .tbl_entry(tbl_entry),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev_addr(cmd_dev_addr),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_ack_err(rsp_ack_err), .adc_rst_n(adc_rst_n), .busy(busy), .done(done),
    .error(error), .err_idx(err_idx), .retry_total(retry_total)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [4] = '{16'h0102, 16'h0304, 16'h0506, 16'hDEAD};

  always_comb begin
    tbl_entry = 16'hDEAD;
    if (tbl_idx < 8'd3) tbl_entry = rom[tbl_idx[1:0]];
  end

  typedef struct {
    int         idx;
    logic [7:0] rg;
    logic [7:0] dt;
  } cmd_t;

  typedef struct {
    string name;
    int    fail_entry;
    int    fail_times;
    bit    fail_to;
    int    stall_entry;
    int    late_entry;
    bit    exp_done;
    bit    exp_error;
    int    exp_err_idx;
    int    exp_retry;
  } vec_t;

  cmd_t exp_q[$];
  vec_t vecs[8];

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  int p_fail_entry = -1, p_fail_times = 0, p_late = -1, p_stall = -1;
  bit p_fail_to = 1'b0;
  int attempts[NREG];
  int rsp_cd = 0;
  bit rsp_nack = 1'b0;
  int exp_rise = 0;
  bit stall_armed = 1'b0;
  int stall_left = 0, stall_cycles = 0, stall_bad = 0;
  bit force_ready_low = 1'b0;
  int n_accept = 0, n_pushed = 0, adc_low_cnt = 0, settle_gap = -1, adc_rise_cyc = 0;
  bit first_cv_pending = 1'b0;
  logic prev_cv = 1'b0, prev_adc = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(string n, int fe, int ft, bit fto, int se, int le,
                              bit d, bit er, int ei, int rt);
    vec_t v;
    v.name = n; v.fail_entry = fe; v.fail_times = ft; v.fail_to = fto;
    v.stall_entry = se; v.late_entry = le; v.exp_done = d; v.exp_error = er;
    v.exp_err_idx = ei; v.exp_retry = rt;
    return v;
  endfunction

  // Arm the responder and build the expected command stream for one run.
  task automatic setup(input vec_t v);
    cmd_t it;
    int   fails, tries;
    logic [15:0] w;
    p_fail_entry = v.fail_entry; p_fail_times = v.fail_times; p_fail_to = v.fail_to;
    p_late = v.late_entry; p_stall = v.stall_entry;
    for (int e = 0; e < NREG; e++) attempts[e] = 0;
    exp_q.delete();
    exp_rise = 0; rsp_cd = 0;
    stall_armed = (v.stall_entry >= 0); stall_left = 0; stall_cycles = 0; stall_bad = 0;
    n_accept = 0; n_pushed = 0; adc_low_cnt = 0; settle_gap = -1;
    for (int e = 0; e < NREG; e++) begin
      fails = (e == v.fail_entry) ? v.fail_times : 0;
      tries = (fails > MAXR) ? MAXR + 1 : fails + 1;
      w = rom[e];
      for (int k = 0; k < tries; k++) begin
        it.idx = e; it.rg = w[15:8]; it.dt = w[7:0];
        exp_q.push_back(it);
        n_pushed++;
      end
      if (fails > MAXR) break;
    end
  endtask

  // I2C master model: drives cmd_ready/rsp_* and scoreboards accepted commands.
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    cmd_t it;
    int   e, fe;
    bit   fl;
    rsp_valid = 1'b0;
    rsp_ack_err = 1'b0;
    if (rsp_cd > 0) begin
      rsp_cd--;
      if (rsp_cd == 0) begin
        rsp_valid = 1'b1;
        rsp_ack_err = rsp_nack;
      end
    end
    if (busy && !adc_rst_n) adc_low_cnt++;
    if (adc_rst_n && !prev_adc) begin
      adc_rise_cyc = cyc;
      first_cv_pending = 1'b1;
    end
    if (cmd_valid && !prev_cv) begin
      if (first_cv_pending) begin
        settle_gap = cyc - adc_rise_cyc;
        first_cv_pending = 1'b0;
      end
      if (exp_rise != 0) begin
        check("retry_issue_edge", cyc, exp_rise);
        exp_rise = 0;
      end
    end
    prev_cv = cmd_valid;
    prev_adc = adc_rst_n;

    // Stalled entry also receives a stray NACK pulse, which must be ignored.
    if (stall_armed && cmd_valid && exp_q.size() > 0 && exp_q[0].idx == p_stall) begin
      stall_left = 10;
      stall_armed = 1'b0;
      rsp_valid = 1'b1;
      rsp_ack_err = 1'b1;
    end
    if (force_ready_low) begin
      cmd_ready = 1'b0;
    end else if (stall_left > 0) begin
      cmd_ready = 1'b0;
      stall_left--;
      stall_cycles++;
      if (!cmd_valid || exp_q.size() == 0 || cmd_reg !== exp_q[0].rg || cmd_data !== exp_q[0].dt)
        stall_bad++;
    end else begin
      cmd_ready = 1'b1;
    end

    if (cmd_valid && cmd_ready) begin
      n_accept++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_cmd: got reg 0x%0h data 0x%0h, expected no command", cmd_reg, cmd_data);
      end else begin
        it = exp_q.pop_front();
        check("cmd_reg", 32'(cmd_reg), 32'(it.rg));
        check("cmd_data", 32'(cmd_data), 32'(it.dt));
        check("cmd_dev_addr", 32'(cmd_dev_addr), 32'h40);
        e = it.idx;
        attempts[e]++;
        fl = (e == p_fail_entry) && (attempts[e] <= p_fail_times);
        if (fl && p_fail_to) begin
          fe = cyc + 1 + TO;
        end else begin
          rsp_cd = (e == p_late) ? TO : 3;
          rsp_nack = fl;
          fe = cyc + 1 + 3;
        end
        if (fl && attempts[e] <= MAXR) exp_rise = fe + BO;
      end
    end
  end

  task automatic wait_end(input int limit);
    int n = 0;
    while (!(done || error) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("run_finished", 32'(done | error), 32'd1);
  endtask

  task automatic launch(input bit via_reset);
    if (via_reset) rst = 1'b0;
    else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit via_reset);
    setup(v);
    launch(via_reset);
    check({v.name, ":entry_busy"}, 32'(busy), 32'd1);
    check({v.name, ":entry_adc_rst_n"}, 32'(adc_rst_n), 32'd0);
    check({v.name, ":entry_flags"}, {16'd0, 6'd0, done, error, retry_total}, 32'd0);
    check({v.name, ":entry_err_idx"}, 32'(err_idx), 32'd0);
    wait_end(2000);
    check({v.name, ":done"}, 32'(done), 32'(v.exp_done));
    check({v.name, ":error"}, 32'(error), 32'(v.exp_error));
    check({v.name, ":err_idx"}, 32'(err_idx), 32'(v.exp_err_idx));
    check({v.name, ":retry_total"}, 32'(retry_total), 32'(v.exp_retry));
    check({v.name, ":busy_end"}, 32'(busy), 32'd0);
    check({v.name, ":adc_rst_n_end"}, 32'(adc_rst_n), 32'd1);
    check({v.name, ":cmds_left"}, 32'(exp_q.size()), 32'd0);
    check({v.name, ":accepts"}, 32'(n_accept), 32'(n_pushed));
    check({v.name, ":adc_low_cycles"}, 32'(adc_low_cnt), 32'(RSTC));
    check({v.name, ":settle_gap"}, 32'(settle_gap), 32'(SETC + 1));
    if (v.stall_entry >= 0) begin
      check({v.name, ":stall_cycles"}, 32'(stall_cycles), 32'd10);
      check({v.name, ":stall_unstable"}, 32'(stall_bad), 32'd0);
    end
  endtask

  initial begin
    int n;
    vecs[0] = mk("clean",              -1, 0, 1'b0, -1, -1, 1'b1, 1'b0, 0, 0);
    vecs[1] = mk("ready_stall_e1",     -1, 0, 1'b0,  1, -1, 1'b1, 1'b0, 0, 0);
    vecs[2] = mk("nack_e1_once",        1, 1, 1'b0, -1, -1, 1'b1, 1'b0, 0, 1);
    vecs[3] = mk("nack_e2_exhaust",     2, 3, 1'b0, -1, -1, 1'b0, 1'b1, 2, 2);
    vecs[4] = mk("timeout_e0_once",     0, 1, 1'b1, -1, -1, 1'b1, 1'b0, 0, 1);
    vecs[5] = mk("rsp_at_expiry_e1",   -1, 0, 1'b0, -1,  1, 1'b1, 1'b0, 0, 0);
    vecs[6] = mk("nack_e0_max",         0, 2, 1'b0, -1, -1, 1'b1, 1'b0, 0, 2);
    vecs[7] = mk("timeout_e2_exhaust",  2, 3, 1'b1, -1, -1, 1'b0, 1'b1, 2, 2);

    repeat (3) @(negedge clk);
    check("reset_adc_rst_n", 32'(adc_rst_n), 32'd0);
    check("reset_cmd_valid", 32'(cmd_valid), 32'd0);
    check("reset_cmd", {16'd0, cmd_reg, cmd_data}, 32'd0);
    check("reset_tbl_idx", 32'(tbl_idx), 32'd0);
    check("reset_flags", {29'd0, busy, done, error}, 32'd0);
    check("reset_err_idx", 32'(err_idx), 32'd0);
    check("reset_retry_total", 32'(retry_total), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i == 0);

    // start pulses while busy must not restart the run
    setup(vecs[0]);
    launch(1'b0);
    n = 0;
    while (!adc_rst_n && n < 100) begin @(negedge clk); n++; end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(2000);
    check("busy_start:done", 32'(done), 32'd1);
    check("busy_start:accepts", 32'(n_accept), 32'(NREG));
    check("busy_start:adc_low_cycles", 32'(adc_low_cnt), 32'(RSTC));

    // rst while a command is pending, then auto-start brings it up again
    setup(vecs[0]);
    force_ready_low = 1'b1;
    launch(1'b0);
    n = 0;
    while (!cmd_valid && n < 100) begin @(negedge clk); n++; end
    check("mid_rst:reached_issue", 32'(cmd_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst:cmd_valid", 32'(cmd_valid), 32'd0);
    check("mid_rst:adc_rst_n", 32'(adc_rst_n), 32'd0);
    check("mid_rst:busy", 32'(busy), 32'd0);
    @(negedge clk);
    setup(vecs[0]);
    force_ready_low = 1'b0;
    launch(1'b1);
    check("mid_rst:auto_busy", 32'(busy), 32'd1);
    wait_end(2000);
    check("mid_rst:done", 32'(done), 32'd1);
    check("mid_rst:retry_total", 32'(retry_total), 32'd0);
    check("mid_rst:cmds_left", 32'(exp_q.size()), 32'd0);
    check("mid_rst:accepts", 32'(n_accept), 32'(NREG));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
